// File: rtl/dct_pkg.sv
// Shared constants for the DCT coefficient streamer: word geometry, FSM
// state encoding and the JPEG zig-zag scan table.
package dct_pkg;

   localparam int DATA_WIDTH  = 32;
   localparam int DATA_DEPTH  = 8;
   localparam int TOTAL_WORDS = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      STREAM = 2'd2
   } state_t;

   // Entry k is the raster index (row*8+col) of the k-th coefficient in
   // JPEG zig-zag scan order.
   localparam logic [5:0] ZIGZAG [TOTAL_WORDS] = '{
       6'd0,  6'd1,  6'd8, 6'd16,  6'd9,  6'd2,  6'd3, 6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11,  6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13,  6'd6,  6'd7, 6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

endpackage

// File: rtl/zigzag_rom.sv
// Combinational zig-zag lookup: scan position k to raster index.
module zigzag_rom
   import dct_pkg::*;
(
   input  logic [5:0] k,
   output logic [5:0] raster_idx
);

   // Pure table lookup, no state.
   always_comb begin
      raster_idx = ZIGZAG[k];
   end

endmodule

// File: rtl/dct_coef_streamer.sv
// Captures an 8x8 matrix of Q16.16 DCT coefficients a fixed number of
// cycles after start, then streams them out in zig-zag order over a
// valid/ready handshake.
module dct_coef_streamer #(
   parameter int DATA_WIDTH = dct_pkg::DATA_WIDTH,
   parameter int DATA_DEPTH = dct_pkg::DATA_DEPTH,
   parameter int LATENCY    = 4
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       start,
   input  logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] data_in_matrix,
   output logic                                       busy,
   output logic [DATA_WIDTH-1:0]                      coef_out,
   output logic [5:0]                                 coef_index,
   output logic                                       coef_valid,
   input  logic                                       coef_ready,
   output logic                                       coef_last
);

   import dct_pkg::state_t;
   import dct_pkg::IDLE;
   import dct_pkg::WAIT;
   import dct_pkg::STREAM;
   import dct_pkg::TOTAL_WORDS;

   localparam int         NWORDS   = DATA_DEPTH * DATA_DEPTH;
   localparam logic [3:0] LAT_LOAD = 4'(LATENCY);
   localparam logic [5:0] K_LAST   = 6'(TOTAL_WORDS - 1);

   state_t                  state_q, state_d;
   logic [3:0]              wait_cnt_q, wait_cnt_d;
   logic [5:0]              k_q, k_d;
   logic                    capture;
   logic [DATA_WIDTH-1:0]   buf_q   [NWORDS];
   logic [DATA_WIDTH-1:0]   buf_d   [NWORDS];
   logic [DATA_WIDTH-1:0]   in_word [NWORDS];
   logic [5:0]              raster;

   // Split the flat input bus into words, word i = row*8+col.
   generate
      for (genvar gi = 0; gi < NWORDS; gi++) begin : g_unpack
         assign in_word[gi] = data_in_matrix[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   zigzag_rom u_zigzag (
      .k          (k_q),
      .raster_idx (raster)
   );

   // State register, wait counter and scan counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         k_q        <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         k_q        <= k_d;
      end
   end

   // Next-state logic: start is only honoured in IDLE; the capture edge is
   // the one on which the wait counter already reads zero, so a latency of
   // N captures on the (N+1)th edge after start.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      k_d        = k_q;
      capture    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               wait_cnt_d = LAT_LOAD;
               k_d        = '0;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt_q == 4'd0) begin
               capture = 1'b1;
               k_d     = '0;
               state_d = STREAM;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         STREAM: begin
            if (coef_ready) begin
               if (k_q == K_LAST) begin
                  k_d     = '0;
                  state_d = IDLE;
               end else begin
                  k_d = k_q + 6'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Buffer next value: load every word on the capture edge, otherwise hold
   // so later input changes cannot leak into the stream.
   always_comb begin
      for (int i = 0; i < NWORDS; i++) begin
         buf_d[i] = capture ? in_word[i] : buf_q[i];
      end
   end

   // Coefficient buffer, cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NWORDS; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NWORDS; i++) begin
            buf_q[i] <= buf_d[i];
         end
      end
   end

   // Outputs are decoded from registered state only, so they hold steady
   // while the consumer stalls and read zero outside STREAM.
   always_comb begin
      busy       = (state_q != IDLE);
      coef_valid = (state_q == STREAM);
      coef_index = '0;
      coef_out   = '0;
      coef_last  = 1'b0;
      if (state_q == STREAM) begin
         coef_index = raster;
         coef_out   = buf_q[raster];
         coef_last  = (k_q == K_LAST);
      end
   end

endmodule

// File: tb/tb_dct_coef_streamer.sv
// Bench for dct_coef_streamer: one instance with LATENCY=4, one with
// LATENCY=0, sharing clock, reset, data and ready.
module tb_dct_coef_streamer;

   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            start_drv;
   logic            ready;
   logic            sel;
   logic [DW*64-1:0] data_in;

   logic            start4, start0;
   logic            busy4, busy0, valid4, valid0, last4, last0;
   logic [DW-1:0]   out4, out0;
   logic [5:0]      idx4, idx0;

   wire             obs_busy  = sel ? busy0  : busy4;
   wire             obs_valid = sel ? valid0 : valid4;
   wire             obs_last  = sel ? last0  : last4;
   wire [DW-1:0]    obs_out   = sel ? out0   : out4;
   wire [5:0]       obs_idx   = sel ? idx0   : idx4;

   assign start4 = start_drv & ~sel;
   assign start0 = start_drv & sel;

   always #5 clk = ~clk;

   dct_coef_streamer #(.DATA_WIDTH(DW), .DATA_DEPTH(8), .LATENCY(4)) dut4 (
      .clk            (clk),
      .reset          (reset),
      .start          (start4),
      .data_in_matrix (data_in),
      .busy           (busy4),
      .coef_out       (out4),
      .coef_index     (idx4),
      .coef_valid     (valid4),
      .coef_ready     (ready),
      .coef_last      (last4)
   );

   dct_coef_streamer #(.DATA_WIDTH(DW), .DATA_DEPTH(8), .LATENCY(0)) dut0 (
      .clk            (clk),
      .reset          (reset),
      .start          (start0),
      .data_in_matrix (data_in),
      .busy           (busy0),
      .coef_out       (out0),
      .coef_index     (idx0),
      .coef_valid     (valid0),
      .coef_ready     (ready),
      .coef_last      (last0)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mat      [64];
   logic [31:0] exp_word [64];
   int          zz       [64];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Zig-zag order derived geometrically: walk anti-diagonals s=row+col,
   // going up-right on even s and down-left on odd s.
   task automatic build_zz();
      int n;
      int lo;
      int hi;
      n = 0;
      for (int s = 0; s < 15; s++) begin
         lo = (s > 7) ? s - 7 : 0;
         hi = (s < 7) ? s : 7;
         if (s % 2 == 0) begin
            for (int r = hi; r >= lo; r--) begin
               zz[n] = r * 8 + (s - r);
               n++;
            end
         end else begin
            for (int r = lo; r <= hi; r++) begin
               zz[n] = r * 8 + (s - r);
               n++;
            end
         end
      end
   endtask

   task automatic load_mat();
      for (int i = 0; i < 64; i++) data_in[i*32 +: 32] = mat[i];
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < 64; i++) mat[i] = 32'(i) << 16;
      load_mat();
   endtask

   task automatic fill_random();
      for (int i = 0; i < 64; i++) mat[i] = $urandom;
      load_mat();
   endtask

   task automatic fill_const(input logic [31:0] v);
      for (int i = 0; i < 64; i++) mat[i] = v;
      load_mat();
   endtask

   // One block: start, wait lat+1 edges, then consume the stream.
   // rmode: 0 ready always high, 1 pattern 1,0,0,1, 2 random.
   // inject: extra starts during WAIT, mid-STREAM and on the final handshake.
   // clobber: overwrite the input matrix once streaming has begun.
   // abort_k: assert reset when k reaches this value (-1 = never).
   task automatic do_block(input int lat, input int rmode, input bit inject,
                           input bit clobber, input int abort_k);
      int  k;
      int  cyc;
      bit  rdy;
      for (int i = 0; i < 64; i++) exp_word[i] = mat[zz[i]];
      start_drv = 1'b1;
      @(posedge clk); #1;
      start_drv = 1'b0;
      for (int w = 0; w <= lat; w++) begin
         check("wait_busy", obs_busy, 1);
         check("wait_valid", obs_valid, 0);
         check("wait_out", obs_out, 0);
         check("wait_idx", obs_idx, 0);
         start_drv = inject && (w == 0);
         @(posedge clk); #1;
      end
      start_drv = 1'b0;
      k   = 0;
      cyc = 0;
      while (k < 64 && cyc < 1000) begin
         check("str_valid", obs_valid, 1);
         check("str_busy", obs_busy, 1);
         check("str_out", obs_out, exp_word[k]);
         check("str_idx", obs_idx, zz[k]);
         check("str_last", obs_last, (k == 63));
         if (clobber && cyc == 0) fill_const(32'hFFFF_FFFF);
         if (abort_k >= 0 && k == abort_k) begin
            reset = 1'b1;
            #1;
            check("rst_busy", obs_busy, 0);
            check("rst_valid", obs_valid, 0);
            check("rst_out", obs_out, 0);
            check("rst_idx", obs_idx, 0);
            check("rst_last", obs_last, 0);
            #2;
            reset = 1'b0;
            return;
         end
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         ready     = rdy;
         start_drv = inject && (cyc == 10 || (k == 63 && rdy));
         if (rdy) k++;
         @(posedge clk); #1;
         cyc++;
      end
      start_drv = 1'b0;
      if (k < 64) check("stream_timeout", 64'(k), 64);
      if (rmode == 0) check("consecutive", 64'(cyc), 64);
      check("end_valid", obs_valid, 0);
      check("end_busy", obs_busy, 0);
      check("end_out", obs_out, 0);
      check("end_last", obs_last, 0);
      $display("block lat=%0d rmode=%0d inject=%0d clobber=%0d cycles=%0d", lat, rmode, inject, clobber, cyc);
   endtask

   initial begin
      build_zz();
      reset     = 1'b1;
      start_drv = 1'b0;
      ready     = 1'b0;
      sel       = 1'b0;
      fill_ramp();

      // Outputs idle while reset is held, even with start requested.
      repeat (2) @(posedge clk);
      #1;
      start_drv = 1'b1;
      @(posedge clk); #1;
      check("rst4_busy", busy4, 0);
      check("rst4_valid", valid4, 0);
      check("rst4_out", out4, 0);
      check("rst4_idx", idx4, 0);
      check("rst0_busy", busy0, 0);
      check("rst0_last", last0, 0);
      start_drv = 1'b0;
      reset     = 1'b0;
      $display("reset released");

      fill_ramp();
      do_block(4, 0, 1'b0, 1'b0, -1);   // ramp, full-rate
      fill_ramp();
      do_block(4, 1, 1'b0, 1'b0, -1);   // backpressure pattern
      fill_ramp();
      do_block(4, 0, 1'b1, 1'b1, -1);   // ignored starts, post-capture clobber
      fill_ramp();
      do_block(4, 0, 1'b0, 1'b0, 20);   // reset mid-stream
      fill_random();
      do_block(4, 0, 1'b0, 1'b0, -1);   // restream from index 0 right after reset
      fill_const(32'hFFFF_8000);
      do_block(4, 2, 1'b0, 1'b0, -1);   // negative values, random ready
      fill_random();
      do_block(4, 2, 1'b0, 1'b0, -1);   // random data, random ready

      sel = 1'b1;
      fill_random();
      do_block(0, 0, 1'b1, 1'b0, -1);   // zero latency, start on final handshake
      fill_random();
      do_block(0, 2, 1'b0, 1'b0, -1);   // start one cycle later is accepted

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
